pipe_addsub: RTL

- Parametrised, pipelined N-bit adder/subtractor. Successor to the team's 1-bit full-adder cell.
- Splits the operands into STAGES equal chunks. One chunk is resolved per pipeline stage, and the carry is registered between stages.
- Accepts one operation per cycle over a valid/ready handshake with backpressure. Reports carry-out and signed overflow.
- Sits in datapaths that need wide arithmetic at full clock rate, such as ALU back-ends and accumulators.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/addsub_chunk.sv | 32 +++
 rtl/pipe_addsub.sv | 125 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and helpers for the pipelined adder/subtractor
//
// Purpose : operation encoding and chunk-width helper used by pipe_addsub
//           and its per-stage chunk adder.
// Contents: op_e    - operation select (OP_ADD / OP_SUB)
//           chunk_w - width of one pipeline chunk for a WIDTH/STAGES pair
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Guarded against STAGES < 1 so the divide never sees zero while the
  // top-level elaboration check reports the bad configuration.
  function automatic int chunk_w(input int width, input int stages);
    return (stages < 1) ? width : width / stages;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational CHUNK-bit adder slice with MSB carry tap
//
// Purpose : one slice of the pipelined adder; resolves a single chunk.
// Ports   : a, b      - chunk operands (b already inverted for subtract)
//           cin       - carry into the chunk LSB
//           sum       - chunk sum
//           cout      - carry out of the chunk MSB
//           c_msb_in  - carry into the chunk MSB (signed overflow detection)
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum  = full[CHUNK-1:0];
  assign cout = full[CHUNK];

  // The sum bit is a ^ b ^ carry-in at that position, so the carry into
  // the MSB falls out of the already-computed sum without a second adder.
  assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined WIDTH-bit adder/subtractor with valid/ready flow control
//
// Purpose : adds or subtracts two WIDTH-bit operands, one chunk per stage,
//           at one operation per cycle with full backpressure.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid/in_ready   - input handshake
//           in_a, in_b          - operands
//           in_cin              - carry-in (add) / borrow-in (sub)
//           in_sub              - 0 = add, 1 = subtract
//           out_valid/out_ready - output handshake
//           out_sum             - result, modulo 2^WIDTH
//           out_cout            - carry out of the MSB (sub: 1 = no borrow)
//           out_ovf             - signed two's-complement overflow
//
// Pipeline levels 0..STAGES. Level 0 is the input register holding the
// effective operands. Chunk k reads level k and writes level k+1, so the
// result sits in level STAGES, STAGES edges after the input was captured.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_config
    $error("pipe_addsub: WIDTH must be a positive multiple of STAGES");
  end

  // x_r[k]: chunks below k already hold sum bits (deskew), chunks k and
  // above still hold operand A (skew). At level STAGES it is the full sum.
  logic             vld [0:STAGES];
  logic [WIDTH-1:0] x_r [0:STAGES];
  logic [WIDTH-1:0] y_r [0:STAGES-1];
  logic             c_r [0:STAGES];
  logic             ovf_r;

  logic [CHUNK-1:0] s_w  [0:STAGES-1];
  logic             co_w [0:STAGES-1];
  logic             cm_w [0:STAGES-1];

  logic advance;

  // Whole pipe moves in lockstep; only the output slot can block it.
  assign advance   = !vld[STAGES] || out_ready;
  assign in_ready  = advance;

  assign out_valid = vld[STAGES];
  assign out_sum   = x_r[STAGES];
  assign out_cout  = c_r[STAGES];
  assign out_ovf   = ovf_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a        (x_r[k][k*CHUNK +: CHUNK]),
      .b        (y_r[k][k*CHUNK +: CHUNK]),
      .cin      (c_r[k]),
      .sum      (s_w[k]),
      .cout     (co_w[k]),
      .c_msb_in (cm_w[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= STAGES; i++) begin
        vld[i] <= 1'b0;
      end
      // Only the output-facing data is cleared; inner data is don't-care
      // behind its valid bit and is never loaded into the output slot
      // unless it is valid.
      x_r[STAGES] <= '0;
      c_r[STAGES] <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (advance) begin
      vld[0] <= in_valid;
      if (in_valid) begin
        x_r[0] <= in_a;
        // Subtract is a + ~b + !cin, so both inversions happen here once.
        y_r[0] <= (op_e'(in_sub) == OP_SUB) ? ~in_b : in_b;
        c_r[0] <= in_cin ^ in_sub;
      end

      for (int i = 0; i < STAGES; i++) begin
        vld[i+1] <= vld[i];
        // Data moves only behind a valid entry: bubbles leave the next
        // level's data untouched, so the outputs keep the last result.
        if (vld[i]) begin
          x_r[i+1]                    <= x_r[i];
          x_r[i+1][i*CHUNK +: CHUNK]  <= s_w[i];
          c_r[i+1]                    <= co_w[i];
        end
      end

      for (int i = 1; i < STAGES; i++) begin
        if (vld[i-1]) begin
          y_r[i] <= y_r[i-1];
        end
      end

      // Carry into bit WIDTH-1 vs carry out of it, both from the top chunk.
      if (vld[STAGES-1]) begin
        ovf_r <= cm_w[STAGES-1] ^ co_w[STAGES-1];
      end
    end
  end

endmodule
